adder16_share_arb: RTL and testbench
====================================

# adder16_share_arb

Round-robin arbiter and sequencer that shares one combinational 16-bit ripple adder (`adder_16bit`, instantiated outside this block) among `N_REQ` requesters. It accepts operand sets through a req/gnt handshake and drives the shared adder from registered operands. It then returns the registered sum, carry and requester ID through a valid/ready response port. It sits between the requesting engines and the shared adder instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 16: operand width; must match the shared adder.
- `IDW`, default 2: requester ID width, equal to clog2(`N_REQ`).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  in  `N_REQ`  per-requester request; held high until granted.
- `a_in`  in  `N_REQ*WIDTH`  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `b_in`  in  `N_REQ*WIDTH`  operand B, same packing as `a_in`.
- `cin_in`  in  `N_REQ`  carry-in per requester.
- `gnt`  out  `N_REQ`  one-hot grant, combinational; operands are sampled at the end of the `gnt` cycle.
- `add_a`, `add_b`  out  `WIDTH`  to the shared adder inputs `a` and `b`.
- `add_cin`  out  1  to the shared adder `Cin`.
- `add_y`  in  `WIDTH`  from the shared adder `y`.
- `add_co`  in  1  from the shared adder `Co`.
- `valid_out`  out  1  response valid.
- `out_ready`  in  1  consumer accepts the response.
- `y_out`  out  `WIDTH`  registered sum.
- `co_out`  out  1  registered carry-out.
- `id_out`  out  `IDW`  index of the requester this result belongs to.
- `op_count`  out  16  completed transactions; wraps from 0xFFFF to 0.

## Operation
- Registers:
  - Operand registers: `op_a`, `op_b`, `op_cin`, `op_id`.
  - Response registers: `y_out`, `co_out`, `id_out`.
  - Round-robin pointer `last`.
  - `op_count`.
  - State register.
- `add_a`/`add_b`/`add_cin` are driven directly from `op_a`/`op_b`/`op_cin` in all states.
- State machine:
  - IDLE: if any `req` bit is high, grant the winner, load the operand registers, record the winner in `last`, go to EXEC. Otherwise stay in IDLE.
  - EXEC (exactly 1 cycle): capture `add_y`→`y_out`, `add_co`→`co_out`, `op_id`→`id_out`; go to RESP.
  - RESP: `valid_out`=1.
    - If `out_ready`=1: increment `op_count`.
    - If additionally any `req` is high, grant the winner and load operands in the same cycle, then go to EXEC.
    - If `out_ready`=1 and no `req` is high, go to IDLE.
    - If `out_ready`=0: hold, with no grant.
- Arbitration:
  - Search order is `last`+1, `last`+2, … modulo `N_REQ`.
  - The first requester with `req` high wins.
  - Exactly one `gnt` bit is high, only in grant cycles as defined above; `gnt` is 0 in EXEC and in stalled RESP.
- Requester rules:
  - `req` may be dropped before it is granted; that requester is then not served.
  - After its `gnt`, a requester reasserts `req` for its next operation.
- Response outputs (`y_out`, `co_out`, `id_out`) stay stable while `valid_out`=1 and `out_ready`=0.
- Arithmetic: {`co_out`,`y_out`} = `op_a` + `op_b` + `op_cin`, truncated to `WIDTH`+1 bits. The block checks nothing; correctness comes from the shared adder.

## Timing
- Reset (`rst_n`=0 at a rising edge) gives:
  - State IDLE, `last`=`N_REQ`-1 (requester 0 has top priority first).
  - `op_a`/`op_b`/`op_cin`/`op_id` = 0, so `add_a`/`add_b`/`add_cin` = 0.
  - `valid_out`=0, `y_out`=0, `co_out`=0, `id_out`=0, `op_count`=0.
  - `gnt` is forced to 0 while `rst_n`=0.
- Reset mid-operation aborts the in-flight transaction: no response and no count. A pending requester is regranted normally after reset.
- Latency: `gnt` in cycle t → EXEC in t+1 → `valid_out` high from t+2.
- Back-to-back throughput with `out_ready` tied high: one result every 2 cycles.
- If `req` and `out_ready` rise in the same cycle while in RESP, the grant and the response pop happen in that same cycle.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, then release. Expect all outputs 0, `gnt`=0, and `add_a`/`add_b`=0.
- Single op: `req`[0]=1 with a=0x1234, b=0x0FFF, cin=1. Expect `gnt`=0001 at t, `valid_out` at t+2 with `y_out`=0x2234, `co_out`=0, `id_out`=0, and `op_count`=1 after the pop.
- Carry/wrap: requester 2 sends a=0xFFFF, b=0x0001, cin=0. Expect `y_out`=0x0000, `co_out`=1, `id_out`=2.
- Round robin: all 4 `req` held high and `out_ready`=1. Expect grant order 0,1,2,3,0, with `gnt` pulses 2 cycles apart.
- Backpressure: `out_ready`=0 for 5 cycles with `req`[1] pending. Expect `valid_out` and data held, `gnt`=0 throughout, then `gnt`=0010 in the cycle `out_ready` rises.
- Reset mid-op: assert `rst_n`=0 during EXEC. Expect no `valid_out`, `op_count` unchanged at 0, and a fresh grant to requester 0 after release.

Source files
------------

// File: rtl/adder16_share_arb.sv
// Round-robin arbiter/sequencer sharing one external combinational adder among
// N_REQ requesters: req/gnt operand intake, registered valid/ready result return.
module adder16_share_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    input  logic [N_REQ-1:0]       cin_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_y,
    input  logic                   add_co,
    output logic                   valid_out,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       y_out,
    output logic                   co_out,
    output logic [IDW-1:0]         id_out,
    output logic [15:0]            op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;
    logic             any_req;
    logic             grant_en;
    logic             pop;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [IDW-1:0]   op_id;

    // Round-robin search starting one past the most recent winner
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = IDW'((32'(last) + i) % N_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    // Operand mux for the current winner
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_a   = a_in[i*WIDTH +: WIDTH];
                sel_b   = b_in[i*WIDTH +: WIDTH];
                sel_cin = cin_in[i];
            end
        end
    end

    // Next-state and grant decode
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        grant_en  = 1'b0;
        gnt       = '0;
        case (state)
            S_IDLE: begin
                grant_en = any_req;
                if (any_req) state_nxt = S_EXEC;
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                if (out_ready) begin
                    pop       = 1'b1;
                    grant_en  = any_req;
                    state_nxt = any_req ? S_EXEC : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!rst_n) grant_en = 1'b0;
        if (grant_en) gnt = N_REQ'(1) << winner;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Operand, response, pointer and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= '0;
            last      <= IDW'(N_REQ - 1);
            valid_out <= 1'b0;
            y_out     <= '0;
            co_out    <= 1'b0;
            id_out    <= '0;
            op_count  <= '0;
        end else begin
            if (grant_en) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_cin <= sel_cin;
                op_id  <= winner;
                last   <= winner;
            end
            if (state == S_EXEC) begin
                y_out     <= add_y;
                co_out    <= add_co;
                id_out    <= op_id;
                valid_out <= 1'b1;
            end else if (pop) begin
                valid_out <= 1'b0;
            end
            if (pop) op_count <= op_count + 16'd1;
        end
    end

    assign add_a   = op_a;
    assign add_b   = op_b;
    assign add_cin = op_cin;

endmodule

// File: tb/tb_adder16_share_arb.sv
// Bench for adder16_share_arb: directed scenarios then random traffic, all
// checked against a transaction-level reference model.
module tb_adder16_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] a_arr [4];
    logic [15:0] b_arr [4];
    logic [3:0]  cin_in;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [3:0]  gnt;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_y;
    logic        add_co;
    logic        valid_out;
    logic        out_ready;
    logic [15:0] y_out;
    logic        co_out;
    logic [1:0]  id_out;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    // Reference model state (transaction level)
    bit m_known = 0;
    int m_last, m_count;
    bit m_exec, m_valid;
    int m_ex_y, m_ex_co, m_ex_id;
    int m_y, m_co, m_id;
    int m_opa, m_opb, m_opcin;
    int exp_w;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_in[i*16 +: 16] = a_arr[i];
            b_in[i*16 +: 16] = b_arr[i];
        end
    end

    // Stand-in for the external shared adder
    assign {add_co, add_y} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

    adder16_share_arb #(.N_REQ(4), .WIDTH(16), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .cin_in(cin_in), .gnt(gnt), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_y(add_y), .add_co(add_co),
        .valid_out(valid_out), .out_ready(out_ready), .y_out(y_out),
        .co_out(co_out), .id_out(id_out), .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= 4; i++) begin
            int k;
            k = (last + i) % 4;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    // Let inputs settle, predict the grant, compare every output to the model
    task automatic settle();
        logic [3:0] eg;
        #1;
        exp_w = -1;
        if (rst_n && !m_exec && (!m_valid || out_ready)) exp_w = pick(req, m_last);
        eg = (exp_w < 0) ? 4'b0 : 4'(1 << exp_w);
        if (m_known) begin
            chk("gnt", 32'(gnt), 32'(eg));
            chk("valid_out", 32'(valid_out), 32'(m_valid));
            chk("y_out", 32'(y_out), 32'(m_y));
            chk("co_out", 32'(co_out), 32'(m_co));
            chk("id_out", 32'(id_out), 32'(m_id));
            chk("op_count", 32'(op_count), 32'(m_count & 32'hFFFF));
            chk("add_a", 32'(add_a), 32'(m_opa));
            chk("add_b", 32'(add_b), 32'(m_opb));
            chk("add_cin", 32'(add_cin), 32'(m_opcin));
        end
    endtask

    // Advance one clock and apply the same edge to the model
    task automatic tick();
        int s;
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1; m_last = 3; m_count = 0; m_exec = 0; m_valid = 0;
            m_y = 0; m_co = 0; m_id = 0; m_opa = 0; m_opb = 0; m_opcin = 0;
        end else begin
            if (m_valid && out_ready) begin
                m_count++;
                m_valid = 0;
            end
            if (m_exec) begin
                m_valid = 1; m_y = m_ex_y; m_co = m_ex_co; m_id = m_ex_id; m_exec = 0;
            end
            if (exp_w >= 0) begin
                s = int'(a_arr[exp_w]) + int'(b_arr[exp_w]) + int'(cin_in[exp_w]);
                m_exec = 1; m_ex_y = s % 65536; m_ex_co = s / 65536; m_ex_id = exp_w;
                m_opa = int'(a_arr[exp_w]); m_opb = int'(b_arr[exp_w]);
                m_opcin = int'(cin_in[exp_w]); m_last = exp_w;
            end
        end
        #1;
    endtask

    task automatic drain();
        req = 4'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin settle(); tick(); end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0; out_ready = 1'b0; cin_in = 4'b0;
        for (int i = 0; i < 4; i++) begin a_arr[i] = '0; b_arr[i] = '0; end

        // Reset then idle
        settle(); tick();
        settle(); tick();
        rst_n = 1'b1;
        settle();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_count", 32'(op_count), 0);
        tick();

        // Single op from requester 0
        out_ready = 1'b1;
        a_arr[0] = 16'h1234; b_arr[0] = 16'h0FFF; cin_in = 4'b0001; req = 4'b0001;
        settle(); chk("single_gnt", 32'(gnt), 32'h1); tick();
        req = 4'b0;
        settle(); chk("single_exec_valid", 32'(valid_out), 0); tick();
        settle();
        chk("single_valid", 32'(valid_out), 1);
        chk("single_y", 32'(y_out), 32'h2234);
        chk("single_co", 32'(co_out), 0);
        chk("single_id", 32'(id_out), 0);
        tick();
        settle(); chk("single_count", 32'(op_count), 1); tick();

        // Carry and wrap from requester 2
        a_arr[2] = 16'hFFFF; b_arr[2] = 16'h0001; cin_in = 4'b0000; req = 4'b0100;
        settle(); chk("carry_gnt", 32'(gnt), 32'h4); tick();
        req = 4'b0;
        settle(); tick();
        settle();
        chk("carry_y", 32'(y_out), 0);
        chk("carry_co", 32'(co_out), 1);
        chk("carry_id", 32'(id_out), 2);
        tick();
        drain();

        // Round robin from a fresh reset
        rst_n = 1'b0; settle(); tick(); rst_n = 1'b1;
        req = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 4; i++) begin
                a_arr[i] = 16'($urandom); b_arr[i] = 16'($urandom);
            end
            cin_in = 4'($urandom);
            settle();
            chk("rr_gnt", 32'(gnt), (c % 2 == 0) ? (1 << ((c / 2) % 4)) : 0);
            tick();
        end
        drain();

        // Backpressure with requester 1 pending
        req = 4'b0001; out_ready = 1'b0;
        settle(); chk("bp_first_gnt", 32'(gnt), 32'h1); tick();
        req = 4'b0010; a_arr[1] = 16'hBEEF; b_arr[1] = 16'h1111;
        settle(); tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_valid", 32'(valid_out), 1);
            chk("bp_gnt", 32'(gnt), 0);
            tick();
        end
        out_ready = 1'b1;
        settle(); chk("bp_release_gnt", 32'(gnt), 32'h2); tick();
        drain();

        // Reset during EXEC
        rst_n = 1'b0; settle(); tick(); rst_n = 1'b1;
        req = 4'b0001;
        settle(); chk("mid_gnt", 32'(gnt), 32'h1); tick();
        rst_n = 1'b0;
        settle(); chk("mid_rst_gnt", 32'(gnt), 0); tick();
        rst_n = 1'b1;
        settle();
        chk("mid_valid", 32'(valid_out), 0);
        chk("mid_count", 32'(op_count), 0);
        chk("mid_regrant", 32'(gnt), 32'h1);
        tick();
        drain();

        // Random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom % 80) != 0;
            req = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < 4; i++) begin
                a_arr[i] = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
                b_arr[i] = 16'($urandom);
            end
            cin_in = 4'($urandom);
            settle(); tick();
        end
        rst_n = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
